// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// opcode classes, select/ALU codes and trap causes.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_LUI, CL_ILLEGAL
    } opclass_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_IMM    = 2'b01;
    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;
    localparam logic [1:0] A_RS1     = 2'b00;
    localparam logic [1:0] A_PC      = 2'b01;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    function automatic opclass_e decode_class(input logic [6:0] op);
        case (op)
            OP_R:      return CL_R;
            OP_I:      return CL_I;
            OP_LOAD:   return CL_LOAD;
            OP_STORE:  return CL_STORE;
            OP_BRANCH: return CL_BRANCH;
            OP_JAL:    return CL_JAL;
            OP_LUI:    return CL_LUI;
            default:   return CL_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/riscv_uc_mc_if.sv
// Control-unit boundary: opcode/memory handshake in, datapath control nets out.
interface riscv_uc_mc_if #(
    parameter int OPCODE_W = 7,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                branch;
    logic                pc_load;
    logic                pc_reset;
    logic                ir_load;
    logic                mem_re;
    logic                mem_we;
    logic                reg_file_write;
    logic [SEL_W-1:0]    alu_op;
    logic [SEL_W-1:0]    select_mux_1;
    logic [SEL_W-1:0]    select_mux_2;
    logic [SEL_W-1:0]    select_mux_3;
    logic [SEL_W-1:0]    select_mux_4;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, mem_ready,
        output branch, pc_load, pc_reset, ir_load, mem_re, mem_we,
               reg_file_write, alu_op, select_mux_1, select_mux_2,
               select_mux_3, select_mux_4, trap, trap_cause, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  branch, pc_load, pc_reset, ir_load, mem_re, mem_we,
               reg_file_write, alu_op, select_mux_1, select_mux_2,
               select_mux_3, select_mux_4, trap, trap_cause, retired
    );
endinterface

// File: rtl/riscv_uc_mem_timer.sv
// Per-access wait counter; flags a timeout once MEM_TIMEOUT stalled cycles
// have elapsed without mem_ready.
module riscv_uc_mem_timer #(
    parameter int WAIT_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic timeout_o
);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i)
            wait_cnt_d = '0;
        else if (count_i)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end

    assign timeout_o = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/riscv_uc_mc.sv
// Multicycle RISC-V control FSM with variable-latency memory handshake,
// illegal-opcode/timeout traps and a retired-instruction counter.
module riscv_uc_mc
    import riscv_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int SEL_W       = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    riscv_uc_mc_if.master bus
);
    state_e           state_q, state_d;
    opclass_e         class_q, class_d, decoded;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_phase, stall, timeout, retire;

    assign decoded   = decode_class(7'(bus.opcode));
    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign stall     = mem_phase && !bus.mem_ready;

    riscv_uc_mem_timer #(
        .WAIT_W      (WAIT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!stall),
        .count_i   (stall),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d            = state_q;
        cause_d            = cause_q;
        bus.branch         = 1'b0;
        bus.pc_load        = 1'b0;
        bus.pc_reset       = 1'b0;
        bus.ir_load        = 1'b0;
        bus.mem_re         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.reg_file_write = 1'b0;
        bus.alu_op         = '0;
        bus.select_mux_1   = '0;
        bus.select_mux_2   = '0;
        bus.select_mux_3   = '0;
        bus.select_mux_4   = '0;
        bus.trap           = 1'b0;
        case (state_q)
            ST_RST: begin
                bus.pc_reset = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_FETCH: begin
                bus.mem_re       = 1'b1;
                bus.select_mux_4 = SEL_W'(A_PC);
                if (bus.mem_ready) begin
                    bus.ir_load = 1'b1;
                    state_d     = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (decoded == CL_ILLEGAL) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CL_R, CL_I: begin
                        bus.alu_op       = SEL_W'(ALU_FUNCT);
                        bus.select_mux_2 = SEL_W'((class_q == CL_I) ? B_IMM : B_RS2);
                        state_d          = ST_WB;
                    end
                    CL_LUI: state_d = ST_WB;
                    CL_LOAD, CL_STORE: begin
                        bus.alu_op       = SEL_W'(ALU_ADD);
                        bus.select_mux_2 = SEL_W'(B_IMM);
                        state_d          = ST_MEM;
                    end
                    CL_BRANCH: begin
                        bus.alu_op       = SEL_W'(ALU_SUB);
                        bus.branch       = 1'b1;
                        bus.pc_load      = 1'b1;
                        bus.select_mux_1 = SEL_W'(PC_IMM);
                        state_d          = ST_FETCH;
                    end
                    CL_JAL: begin
                        bus.pc_load        = 1'b1;
                        bus.select_mux_1   = SEL_W'(PC_IMM);
                        bus.reg_file_write = 1'b1;
                        bus.select_mux_3   = SEL_W'(WB_PC4);
                        state_d            = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                // A store finishes here, so the PC advances on the completing cycle
                bus.mem_we = (class_q == CL_STORE);
                bus.mem_re = (class_q != CL_STORE);
                if (bus.mem_ready) begin
                    if (class_q == CL_STORE) begin
                        bus.pc_load      = 1'b1;
                        bus.select_mux_1 = SEL_W'(PC_PLUS4);
                        state_d          = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                bus.reg_file_write = 1'b1;
                bus.pc_load        = 1'b1;
                bus.select_mux_1   = SEL_W'(PC_PLUS4);
                case (class_q)
                    CL_LOAD: bus.select_mux_3 = SEL_W'(WB_MEM);
                    CL_LUI:  bus.select_mux_3 = SEL_W'(WB_IMM);
                    default: bus.select_mux_3 = SEL_W'(WB_ALU);
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: bus.trap = 1'b1;
            default: state_d = ST_RST;
        endcase
    end

    assign class_d   = (state_q == ST_DECODE) ? decoded : class_q;
    assign retire    = (state_d == ST_FETCH) &&
                       ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));
    assign retired_d = retire ? retired_q + 1'b1 : retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RST;
            class_q   <= CL_R;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign bus.trap_cause = cause_q;
    assign bus.retired    = retired_q;
endmodule

// File: doc/riscv_uc_mc.md
Name: riscv_uc_mc

Overview:
- Next-generation multicycle control unit for the riscv core.
- Replaces the fixed-latency controller with a parametrised FSM. It supports:
  - variable-latency memory through a ready handshake;
  - an extended opcode set (R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI);
  - illegal-opcode and memory-timeout traps;
  - a retired-instruction counter.
- Sits beside riscv_dp inside the riscv top. It drives the same control nets plus ir_load, trap and retire signals.

Parameters:
- OPCODE_W, 7, opcode field width.
- SEL_W, 2, width of each select_mux_N and alu_op.
- MEM_TIMEOUT, 15, max wait cycles per memory access before trap (1..2^WAIT_W-1).
- WAIT_W, 4, wait counter width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  instruction opcode from datapath IR
- mem_ready  in  1  memory completes current read/write this cycle
- branch  out  1  datapath gates pc_load with ALU zero
- pc_load  out  1  PC register load enable
- pc_reset  out  1  PC clear
- ir_load  out  1  instruction register load
- mem_re  out  1  memory read request, level, held until mem_ready
- mem_we  out  1  memory write request, level, held until mem_ready
- reg_file_write  out  1  register file write enable
- alu_op  out  SEL_W  00 add, 01 sub, 10 funct decode
- select_mux_1  out  SEL_W  PC source: 00 pc+4, 01 pc+imm
- select_mux_2  out  SEL_W  ALU B: 00 rs2, 01 imm
- select_mux_3  out  SEL_W  writeback: 00 ALU, 01 mem data, 10 pc+4, 11 imm
- select_mux_4  out  SEL_W  ALU A: 00 rs1, 01 pc
- trap  out  1  sticky, high in TRAP state
- trap_cause  out  2  00 none, 01 memory timeout, 10 illegal opcode
- retired  out  CNT_W  count of completed instructions

Behaviour:
- reset is asynchronous and active-high; one clock, clk.
  - While reset is high: state=RST, retired=0, wait_cnt=0, trap_cause=00.
- Outputs are Moore, decoded from the state register plus the latched opcode class. The only Mealy term is mem_ready (ir_load, pc_load on store completion).
- Every output not listed for a state is 0; selects default to 00.
- RST: pc_reset=1. Next state is FETCH, so exactly one cycle after reset release.
- FETCH: mem_re=1, select_mux_4=01.
  - mem_ready=1: ir_load=1 in the same cycle, next DECODE, wait_cnt cleared.
  - mem_ready=0: wait_cnt increments. When wait_cnt==MEM_TIMEOUT with mem_ready still 0: next TRAP, cause 01.
- DECODE:
  - Latch opcode class into an internal register.
  - Unknown opcode: next TRAP, cause 10.
  - Otherwise: next EXEC.
- EXEC, per class:
  - R: alu_op=10, select_mux_2=00. Next WB.
  - I-ALU: alu_op=10, select_mux_2=01. Next WB.
  - LUI: next WB (writeback 11).
  - LOAD/STORE: alu_op=00, select_mux_2=01 (address calc). Next MEM.
  - BRANCH: alu_op=01, branch=1, pc_load=1, select_mux_1=01. Next FETCH; retire.
  - JAL: pc_load=1, select_mux_1=01, reg_file_write=1, select_mux_3=10. Next FETCH; retire.
- MEM: LOAD holds mem_re=1; STORE holds mem_we=1.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_load=1 (select_mux_1=00) in that cycle, goes to FETCH, retires.
  - The timeout rule is identical to FETCH.
- WB: reg_file_write=1, pc_load=1, select_mux_1=00.
  - select_mux_3: 00 (R/I), 01 (LOAD), 11 (LUI).
  - Next FETCH; retire.
- Retire: retired increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps to 0 modulo 2^CNT_W.
- TRAP: all enables 0, trap=1, trap_cause held. Only reset exits.
- mem_re and mem_we are never both 1.
- reset mid-access drops mem_re/mem_we asynchronously.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_LUI=0110111);
  - state encoding;
  - mux-select and alu_op codes;
  - trap cause codes.
- One natural sub-module: riscv_uc_mem_timer (wait counter + timeout compare), instantiated once and cleared on entering FETCH/MEM.

Test Plan:
- R-type, mem_ready tied 1 -> RST, FETCH, DECODE, EXEC, WB, FETCH. reg_file_write=1 only in WB; retired 0->1 on the 5th cycle after reset release.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_re held 4 cycles, then WB with select_mux_3=01; retired +1.
- STORE, mem_ready on first MEM cycle -> mem_we=1 and pc_load=1 in that same cycle, mem_re=0; next state FETCH.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=15 -> trap=1, cause=01, after 16 FETCH cycles. Outputs stay 0 until reset, which returns to RST.
- opcode=1111111 -> DECODE to TRAP, cause=10; retired unchanged.
- CNT_W=4, 17 single-cycle R-type instructions -> retired wraps 15->0->1. Asserting reset during a MEM wait clears mem_re immediately and sets retired=0.
